// File: rtl/mem_dsram_responder.sv
// Data-memory responder for the MEM stage: word-addressed SRAM behind an
// IDLE/BUSY/DONE handshake with LFSR-driven pseudo-random access latency.
module mem_dsram_responder #(
  parameter int          DEPTH_LOG2 = 12,
  parameter int          LAT_MIN    = 1,
  parameter int          LAT_MASK   = 3,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_i_ren,
  input  logic        MEM_i_wen,
  input  logic [31:0] MEM_i_addr,
  input  logic [31:0] MEM_i_wdata,
  input  logic [3:0]  MEM_i_wstrb,
  input  logic        MEM_pipe_advance,
  output logic [31:0] MEM_o_rdata,
  output logic        MEM_rvalid,
  output logic        MEM_wready
);

  localparam logic [15:0] SEED =
    (LFSR_SEED == 16'h0) ? 16'hACE1 : LFSR_SEED;
  localparam int DEPTH = 2 ** DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t                state;
  logic [15:0]           lfsr;
  logic [4:0]            cnt;
  logic [4:0]            lat;
  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic                  wen_q;
  logic                  last;
  logic                  commit;
  logic                  fb;
  logic                  unused_addr;

  logic [31:0] mem [DEPTH];

  assign unused_addr = ^{MEM_i_addr[1:0], MEM_i_addr[31:DEPTH_LOG2+2]};

  // Fibonacci taps 16,14,13,11
  assign fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign lat = 5'(LAT_MIN) + {1'b0, lfsr[3:0] & 4'(LAT_MASK)};

  assign last   = (state == BUSY) && (cnt == 5'd1);
  assign commit = last && wen_q;

  assign MEM_rvalid = (state == DONE) || ((state == IDLE) && !MEM_i_ren);
  assign MEM_wready = (state == DONE) || ((state == IDLE) && !MEM_i_wen);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      lfsr        <= SEED;
      cnt         <= '0;
      idx         <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      wen_q       <= 1'b0;
      MEM_o_rdata <= '0;
    end else begin
      lfsr <= {lfsr[14:0], fb};
      unique case (state)
        IDLE: begin
          if (MEM_i_ren || MEM_i_wen) begin
            idx     <= MEM_i_addr[DEPTH_LOG2+1:2];
            wdata_q <= MEM_i_wdata;
            wstrb_q <= MEM_i_wstrb;
            wen_q   <= MEM_i_wen;
            cnt     <= lat;
            state   <= BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt - 5'd1;
          if (last) begin
            MEM_o_rdata <= mem[idx];
            state       <= DONE;
          end
        end
        DONE: begin
          if (MEM_pipe_advance) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // array is not reset; writes land only on the final BUSY cycle
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule
